// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register-file slave.
package axil_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 64;
  localparam int unsigned MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  // Replace each byte of old_v with the matching byte of new_v where strb is set.
  // Operates at the widest supported data width; narrower callers zero-extend.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_v,
    input logic [MAX_DATA_WIDTH-1:0] new_v,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_v;
    for (int k = 0; k < int'(MAX_STRB_WIDTH); k++) begin
      if (strb[k]) res[k*8 +: 8] = new_v[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_regfile_core.sv
// Register storage with a byte-strobed write port and an asynchronous read mux.
module axil_regfile_core
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_we,
  input  logic [IDX_W-1:0]               i_widx,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
  input  logic [IDX_W-1:0]               i_ridx,
  output logic [DATA_WIDTH-1:0]          o_rdata_c,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // Byte-lane write into the addressed register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (i_widx == IDX_W'(i)) begin
          r_regs[i] <= DATA_WIDTH'(byte_merge(64'(r_regs[i]), 64'(i_wdata), 8'(i_wstrb)));
        end
      end
    end
  end

  // Read mux; indices past NUM_REGS read as zero.
  always_comb begin
    o_rdata_c = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (i_ridx == IDX_W'(i)) o_rdata_c = r_regs[i];
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave exposing a NUM_REGS x DATA_WIDTH register file.
// Optional feature macro: AXIL_PROT_CHECK_EN -- unprivileged accesses (prot[0]==0) get SLVERR.
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * STRB_W);

  if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_dw
    $error("axil_slave_regfile: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 1) begin : g_bad_nr
    $error("axil_slave_regfile: NUM_REGS must be at least 1");
  end

  wstate_e write_state, w_write_next;
  rstate_e read_state, w_read_next;

  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [2:0]            r_awprot;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  resp_e                 r_bresp;
  resp_e                 r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_hs, w_w_hs, w_ar_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_c_addr;
  logic [DATA_WIDTH-1:0] w_c_data;
  logic [STRB_W-1:0]     w_c_strb;
  logic                  w_c_err;
  logic                  w_rd_err;
  logic [DATA_WIDTH-1:0] w_rdata_c;
  logic                  w_unused_prot;

  // Readies and valids decode directly from the state flops.
  assign awready = (write_state == W_IDLE) || (write_state == W_HAVE_W);
  assign wready  = (write_state == W_IDLE) || (write_state == W_HAVE_AW);
  assign bvalid  = (write_state == W_RESP);
  assign arready = (read_state == R_IDLE);
  assign rvalid  = (read_state == R_DATA);
  assign bresp   = r_bresp;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_ar_hs = arvalid && arready;

  // Commit operands: the half already held comes from the latch, the other from the bus.
  assign w_c_addr = (write_state == W_HAVE_AW) ? r_awaddr : awaddr;
  assign w_c_data = (write_state == W_HAVE_W)  ? r_wdata  : wdata;
  assign w_c_strb = (write_state == W_HAVE_W)  ? r_wstrb  : wstrb;

`ifdef AXIL_PROT_CHECK_EN
  logic [2:0] w_c_prot;
  assign w_c_prot = (write_state == W_HAVE_AW) ? r_awprot : awprot;
  assign w_c_err  = (w_c_addr >= ADDR_LIMIT) || !w_c_prot[0];
  assign w_rd_err = (araddr >= ADDR_LIMIT) || !arprot[0];
`else
  assign w_c_err  = (w_c_addr >= ADDR_LIMIT);
  assign w_rd_err = (araddr >= ADDR_LIMIT);
`endif
  assign w_unused_prot = ^{awprot, arprot, r_awprot};

  // Write channel next-state and commit decode.
  always_comb begin
    w_write_next = write_state;
    w_commit     = 1'b0;
    case (write_state)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit     = 1'b1;
          w_write_next = W_RESP;
        end else if (w_aw_hs) begin
          w_write_next = W_HAVE_AW;
        end else if (w_w_hs) begin
          w_write_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_w_hs) begin
          w_commit     = 1'b1;
          w_write_next = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (w_aw_hs) begin
          w_commit     = 1'b1;
          w_write_next = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) w_write_next = W_IDLE;
      end
      default: w_write_next = W_IDLE;
    endcase
  end

  // Write channel state, half-transaction latches and response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_state <= W_IDLE;
      r_awaddr    <= '0;
      r_awprot    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bresp     <= RESP_OKAY;
    end else begin
      write_state <= w_write_next;
      if (w_aw_hs) begin
        r_awaddr <= awaddr;
        r_awprot <= awprot;
      end
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_commit) r_bresp <= w_c_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Read channel next-state.
  always_comb begin
    w_read_next = read_state;
    case (read_state)
      R_IDLE:  if (w_ar_hs) w_read_next = R_DATA;
      R_DATA:  if (rready)  w_read_next = R_IDLE;
      default: w_read_next = R_IDLE;
    endcase
  end

  // Read channel state and captured response; sampled before same-edge writes land.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_state <= R_IDLE;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      read_state <= w_read_next;
      if (w_ar_hs) begin
        r_rdata <= w_rd_err ? '0 : w_rdata_c;
        r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  axil_regfile_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (reset),
    .i_we      (w_commit && !w_c_err),
    .i_widx    (w_c_addr[ADDR_LSB +: IDX_W]),
    .i_wdata   (w_c_data),
    .i_wstrb   (w_c_strb),
    .i_ridx    (araddr[ADDR_LSB +: IDX_W]),
    .o_rdata_c (w_rdata_c),
    .o_regs    (regs_o)
  );

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Self-checking bench for axil_slave_regfile (32-bit data, 16 registers).
module tb_axil_slave_regfile;
  import axil_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;
  localparam int unsigned SW = DW / 8;
`ifdef AXIL_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [AW-1:0]  awaddr;
  logic [2:0]     awprot;
  logic           awvalid, awready;
  logic [DW-1:0]  wdata;
  logic [SW-1:0]  wstrb;
  logic           wvalid, wready;
  logic [1:0]     bresp;
  logic           bvalid, bready;
  logic [AW-1:0]  araddr;
  logic [2:0]     arprot;
  logic           arvalid, arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rvalid, rready;
  logic [NR*DW-1:0] regs_o;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] mdl [NR];

  axil_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] merge_ref(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [1:0] resp_ref(input logic [31:0] addr, input logic [2:0] prot);
    logic err;
    err = (addr >= 32'(NR * SW)) || (PROT_EN && !prot[0]);
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [NR*DW-1:0] flat_ref();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < int'(NR); i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [2:0] prot,
                                      input logic [31:0] data, input logic [3:0] strb);
    if (resp_ref(addr, prot) == 2'b00) mdl[addr[5:2]] = merge_ref(mdl[addr[5:2]], data, strb);
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_aw(input logic [31:0] a, input logic [2:0] p);
    int n;
    n = 0;
    awaddr = a; awprot = p; awvalid = 1'b1;
    while (!awready && n < 50) begin tick(); n++; end
    if (!awready) begin
      total++; bad++;
      $display("FAIL aw_timeout: awready=%0b required 1", awready);
    end
    tick();
    awvalid = 1'b0;
  endtask

  task automatic put_w(input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < 50) begin tick(); n++; end
    if (!wready) begin
      total++; bad++;
      $display("FAIL w_timeout: wready=%0b required 1", wready);
    end
    tick();
    wvalid = 1'b0;
  endtask

  task automatic put_both(input logic [31:0] a, input logic [2:0] p,
                          input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    awaddr = a; awprot = p; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!(awready && wready) && n < 50) begin tick(); n++; end
    if (!(awready && wready)) begin
      total++; bad++;
      $display("FAIL both_timeout: awready=%0b wready=%0b required 1 1", awready, wready);
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic put_ar(input logic [31:0] a, input logic [2:0] p);
    int n;
    n = 0;
    araddr = a; arprot = p; arvalid = 1'b1;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) begin
      total++; bad++;
      $display("FAIL ar_timeout: arready=%0b required 1", arready);
    end
    tick();
    arvalid = 1'b0;
  endtask

  task automatic release_b();
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic release_r();
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
      bad++; $display("FAIL reset_resp: got %b required 000000", {bvalid, rvalid, bresp, rresp});
    end
    total++;
    if (rdata !== '0 || regs_o !== '0) begin
      bad++; $display("FAIL reset_data: rdata=%h regs=%h required 0", rdata, regs_o);
    end
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++; $display("FAIL reset_ready: got %b required 111", {awready, wready, arready});
    end
    total++;
    if (dut.write_state !== W_IDLE || dut.read_state !== R_IDLE) begin
      bad++; $display("FAIL reset_state: w=%0d r=%0d required 0 0", dut.write_state, dut.read_state);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_same_cycle();
    awaddr = 32'h4; awprot = 3'b001; awvalid = 1'b1;
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    total++;
    if (bvalid !== 1'b0) begin bad++; $display("FAIL t1_bvalid_early: got %0b required 0", bvalid); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(32'h4, 3'b001, 32'h12345678, 4'hF);
    total++;
    if ({bvalid, bresp} !== 3'b100) begin
      bad++; $display("FAIL t1_b: got %b required 100", {bvalid, bresp});
    end
    total++;
    if (regs_o[1*DW +: DW] !== 32'h12345678) begin
      bad++; $display("FAIL t1_reg1: got %h required 12345678", regs_o[1*DW +: DW]);
    end
    tick();
    total++;
    if ({bvalid, awready, wready} !== 3'b100) begin
      bad++; $display("FAIL t1_hold: got %b required 100", {bvalid, awready, wready});
    end
    release_b();
    total++;
    if (bvalid !== 1'b0) begin bad++; $display("FAIL t1_bdone: got %0b required 0", bvalid); end
  endtask

  task automatic test_w_first();
    int extra;
    wdata = 32'hAABBCCDD; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    total++;
    if ({bvalid, wready, awready} !== 3'b001) begin
      bad++; $display("FAIL t2_have_w: got %b required 001", {bvalid, wready, awready});
    end
    repeat (2) tick();
    awaddr = 32'h4; awprot = 3'b001; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    model_write(32'h4, 3'b001, 32'hAABBCCDD, 4'b0101);
    total++;
    if ({bvalid, bresp} !== 3'b100 || regs_o[1*DW +: DW] !== 32'h12BB56DD) begin
      bad++; $display("FAIL t2_commit: b=%b reg1=%h required 100 12bb56dd", {bvalid, bresp},
                      regs_o[1*DW +: DW]);
    end
    release_b();
    extra = 0;
    repeat (3) begin
      if (bvalid) extra++;
      tick();
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL t2_single_b: extra=%0d required 0", extra); end
  endtask

  task automatic test_read_backpressure();
    rready = 1'b0;
    put_ar(32'h4, 3'b001);
    total++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, mdl[1]}) begin
      bad++; $display("FAIL t3_r: got %b %b %h required 1 00 %h", rvalid, rresp, rdata, mdl[1]);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'h12BB56DD}) begin
        bad++; $display("FAIL t3_hold%0d: got %b %b %h required 1 00 12bb56dd", i, rvalid, rresp, rdata);
      end
    end
    release_r();
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL t3_rdone: got %0b required 0", rvalid); end
  endtask

  task automatic test_out_of_range();
    put_both(32'h40, 3'b001, $urandom, 4'hF);
    total++;
    if ({bvalid, bresp} !== 3'b110 || regs_o !== flat_ref()) begin
      bad++; $display("FAIL t4_wr: b=%b regs=%h required 110 %h", {bvalid, bresp}, regs_o, flat_ref());
    end
    release_b();
    put_ar(32'h40, 3'b001);
    total++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b10, 32'h0}) begin
      bad++; $display("FAIL t4_rd: got %b %b %h required 1 10 0", rvalid, rresp, rdata);
    end
    release_r();
    put_ar(32'h3F, 3'b001);
    total++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, mdl[15]}) begin
      bad++; $display("FAIL t4_last: got %b %b %h required 1 00 %h", rvalid, rresp, rdata, mdl[15]);
    end
    release_r();
  endtask

  task automatic test_rw_same_edge();
    logic [31:0] old_v;
    put_both(32'hC, 3'b001, 32'hCAFE0003, 4'hF);
    model_write(32'hC, 3'b001, 32'hCAFE0003, 4'hF);
    release_b();
    old_v = mdl[3];
    awaddr = 32'hC; awprot = 3'b001; awvalid = 1'b1;
    wdata = 32'h5EED0003; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'hC; arprot = 3'b001; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(32'hC, 3'b001, 32'h5EED0003, 4'hF);
    total++;
    if (rdata !== old_v || regs_o[3*DW +: DW] !== mdl[3]) begin
      bad++; $display("FAIL rw_edge: rdata=%h reg3=%h required %h %h", rdata, regs_o[3*DW +: DW],
                      old_v, mdl[3]);
    end
    release_b();
    release_r();
  endtask

  task automatic test_reset_mid();
    awaddr = 32'h8; awprot = 3'b001; awvalid = 1'b1;
    araddr = 32'h4; arprot = 3'b001; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    total++;
    if (dut.write_state !== W_HAVE_AW || rvalid !== 1'b1) begin
      bad++; $display("FAIL t5_pre: w=%0d rvalid=%0b required 1 1", dut.write_state, rvalid);
    end
    reset = 1'b0;
    #2;
    for (int i = 0; i < int'(NR); i++) mdl[i] = '0;
    total++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0 || rdata !== '0 || regs_o !== '0) begin
      bad++; $display("FAIL t5_reset: got %b rdata=%h regs=%h required 0", {bvalid, rvalid, bresp, rresp},
                      rdata, regs_o);
    end
    tick();
    reset = 1'b1;
    tick();
    put_w(32'h0BADF00D, 4'hF);
    total++;
    if ({bvalid, rvalid} !== 2'b00) begin
      bad++; $display("FAIL t5_abandon: got %b required 00", {bvalid, rvalid});
    end
    put_aw(32'h8, 3'b001);
    model_write(32'h8, 3'b001, 32'h0BADF00D, 4'hF);
    total++;
    if ({bvalid, bresp} !== 3'b100 || regs_o !== flat_ref()) begin
      bad++; $display("FAIL t5_after: b=%b regs=%h required 100 %h", {bvalid, bresp}, regs_o, flat_ref());
    end
    release_b();
  endtask

`ifdef AXIL_PROT_CHECK_EN
  task automatic test_prot();
    logic [31:0] before;
    before = mdl[2];
    put_both(32'h8, 3'b000, 32'h11112222, 4'hF);
    total++;
    if ({bvalid, bresp} !== 3'b110 || regs_o[2*DW +: DW] !== before) begin
      bad++; $display("FAIL t6_unpriv: b=%b reg2=%h required 110 %h", {bvalid, bresp},
                      regs_o[2*DW +: DW], before);
    end
    release_b();
    put_both(32'h8, 3'b001, 32'h11112222, 4'hF);
    model_write(32'h8, 3'b001, 32'h11112222, 4'hF);
    total++;
    if ({bvalid, bresp} !== 3'b100 || regs_o[2*DW +: DW] !== 32'h11112222) begin
      bad++; $display("FAIL t6_priv: b=%b reg2=%h required 100 11112222", {bvalid, bresp},
                      regs_o[2*DW +: DW]);
    end
    release_b();
    put_ar(32'h8, 3'b000);
    total++;
    if ({rresp, rdata} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL t6_rd: got %b %h required 10 0", rresp, rdata);
    end
    release_r();
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 200; it++) begin
      int unsigned kind, sel, gap, dly;
      logic [31:0] addr, data, exp_d;
      logic [2:0]  prot;
      logic [3:0]  strb;
      logic [1:0]  exp_r;
      kind = $urandom_range(0, 3);
      sel  = $urandom_range(0, 9);
      if (sel == 0)      addr = $urandom;
      else if (sel == 1) addr = 32'(64 + $urandom_range(0, 63));
      else               addr = 32'($urandom_range(0, 63));
      prot = 3'($urandom_range(0, 7));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      gap  = $urandom_range(0, 3);
      dly  = $urandom_range(0, 2);
      exp_r = resp_ref(addr, prot);
      if (kind < 3) begin
        if (kind == 0) begin
          put_both(addr, prot, data, strb);
        end else if (kind == 1) begin
          put_aw(addr, prot); repeat (gap) tick(); put_w(data, strb);
        end else begin
          put_w(data, strb); repeat (gap) tick(); put_aw(addr, prot);
        end
        model_write(addr, prot, data, strb);
        total++;
        if ({bvalid, bresp} !== {1'b1, exp_r} || regs_o !== flat_ref()) begin
          bad++; $display("FAIL rnd_wr%0d: b=%b regs=%h required 1%b %h", it, {bvalid, bresp}, regs_o,
                          exp_r, flat_ref());
        end
        repeat (dly) tick();
        release_b();
        total++;
        if (bvalid !== 1'b0) begin bad++; $display("FAIL rnd_bdone%0d: got %0b required 0", it, bvalid); end
      end else begin
        put_ar(addr, prot);
        exp_d = (exp_r == 2'b00) ? mdl[addr[5:2]] : 32'h0;
        repeat (dly) tick();
        total++;
        if ({rvalid, rresp, rdata} !== {1'b1, exp_r, exp_d}) begin
          bad++; $display("FAIL rnd_rd%0d: got %b %b %h required 1 %b %h", it, rvalid, rresp, rdata,
                          exp_r, exp_d);
        end
        release_r();
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < int'(NR); i++) mdl[i] = '0;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_read_backpressure();
    test_out_of_range();
    test_rw_same_edge();
    test_reset_mid();
`ifdef AXIL_PROT_CHECK_EN
    test_prot();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
